// File: rtl/lap_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lap_timer_pkg
// Brief   : Shared BCD time type, digit limits and prescaler sizing helper.
// Revision: 1.0 - initial release
// ============================================================================
package lap_timer_pkg;

    localparam int              BCD_W       = 4;
    localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;

    // Digit order from most to least significant: mm:ss.hh
    typedef struct packed {
        logic [BCD_W-1:0] m_s;
        logic [BCD_W-1:0] m_g;
        logic [BCD_W-1:0] s_s;
        logic [BCD_W-1:0] s_g;
        logic [BCD_W-1:0] hs_s;
        logic [BCD_W-1:0] hs_g;
    } bcd_time_t;

    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lap_fifo.sv
`default_nettype none
// ============================================================================
// Module  : lap_fifo
// Brief   : Small lap capture FIFO; head reads as zero while empty.
// Revision: 1.0 - initial release
// ============================================================================
module lap_fifo #(
    parameter int LAP_DEPTH = 4,
    parameter int WIDTH     = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int c_AW = $clog2(LAP_DEPTH);

    logic [WIDTH-1:0] r_mem [LAP_DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_rd_en;
    logic             w_wr_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_rd_en = pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts it
    assign w_wr_en = push & (~w_full | w_rd_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !clear) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end

    assign dout  = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign empty = w_empty;
    assign full  = w_full;

endmodule
`default_nettype wire

// File: rtl/lap_timer.sv
`default_nettype none
// ============================================================================
// Module  : lap_timer
// Brief   : BCD mm:ss.hh up/down stopwatch with lap capture FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MAX_MIN   = 59,
    parameter int LAP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        lap_pop,
    input  logic        clear,
    input  logic        load,
    input  logic        mode_down,
    input  logic [23:0] preset,
    output logic [23:0] data_out,
    output logic [23:0] lap_out,
    output logic        lap_empty,
    output logic        lap_full,
    output logic        lap_ovf,
    output logic        running,
    output logic        done
);

    localparam int               c_DIV        = CLK_HZ / TICK_HZ;
    localparam int               c_PW         = presc_width(c_DIV);
    localparam logic [c_PW-1:0]  c_PRESC_LAST = c_PW'(c_DIV - 1);
    localparam logic [BCD_W-1:0] c_MM_S       = BCD_W'(MAX_MIN / 10);
    localparam logic [BCD_W-1:0] c_MM_G       = BCD_W'(MAX_MIN % 10);

    bcd_time_t       r_count;
    logic [c_PW-1:0] r_presc;
    logic            r_ss_prev;
    logic            r_lap_prev;
    logic            r_running;
    logic            r_done;
    logic            r_ovf;

    logic            w_ss_edge;
    logic            w_lap_edge;
    logic            w_tick;
    logic            w_reach_zero;
    logic            w_run_after_tick;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_full;
    bcd_time_t       w_count_ticked;
    bcd_time_t       w_preset_clamped;

    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.hs_g != DIGIT_MAX_9) r.hs_g = t.hs_g + 4'd1;
        else begin
            r.hs_g = '0;
            if (t.hs_s != DIGIT_MAX_9) r.hs_s = t.hs_s + 4'd1;
            else begin
                r.hs_s = '0;
                if (t.s_g != DIGIT_MAX_9) r.s_g = t.s_g + 4'd1;
                else begin
                    r.s_g = '0;
                    if (t.s_s != DIGIT_MAX_5) r.s_s = t.s_s + 4'd1;
                    else begin
                        r.s_s = '0;
                        if (t.m_s == c_MM_S && t.m_g == c_MM_G) begin
                            r.m_s = '0;
                            r.m_g = '0;
                        end else if (t.m_g == DIGIT_MAX_9) begin
                            r.m_g = '0;
                            r.m_s = t.m_s + 4'd1;
                        end else begin
                            r.m_g = t.m_g + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // Decrementing zero holds at zero; a borrow into the minutes implies m > 0
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t == '0) r = '0;
        else if (t.hs_g != '0) r.hs_g = t.hs_g - 4'd1;
        else begin
            r.hs_g = DIGIT_MAX_9;
            if (t.hs_s != '0) r.hs_s = t.hs_s - 4'd1;
            else begin
                r.hs_s = DIGIT_MAX_9;
                if (t.s_g != '0) r.s_g = t.s_g - 4'd1;
                else begin
                    r.s_g = DIGIT_MAX_9;
                    if (t.s_s != '0) r.s_s = t.s_s - 4'd1;
                    else begin
                        r.s_s = DIGIT_MAX_5;
                        if (t.m_g != '0) r.m_g = t.m_g - 4'd1;
                        else begin
                            r.m_g = DIGIT_MAX_9;
                            r.m_s = t.m_s - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t bcd_clamp(input bcd_time_t t);
        bcd_time_t r;
        r.hs_g = (t.hs_g > DIGIT_MAX_9) ? DIGIT_MAX_9 : t.hs_g;
        r.hs_s = (t.hs_s > DIGIT_MAX_9) ? DIGIT_MAX_9 : t.hs_s;
        r.s_g  = (t.s_g  > DIGIT_MAX_9) ? DIGIT_MAX_9 : t.s_g;
        r.s_s  = (t.s_s  > DIGIT_MAX_5) ? DIGIT_MAX_5 : t.s_s;
        r.m_s  = (t.m_s  > c_MM_S)      ? c_MM_S      : t.m_s;
        r.m_g  = (t.m_g  > DIGIT_MAX_9) ? DIGIT_MAX_9 : t.m_g;
        // Keep the minutes pair itself within MAX_MIN
        if (r.m_s == c_MM_S && r.m_g > c_MM_G) r.m_g = c_MM_G;
        return r;
    endfunction

    assign w_ss_edge        = start_stop & ~r_ss_prev;
    assign w_lap_edge       = lap & ~r_lap_prev;
    assign w_tick           = r_running && (r_presc == c_PRESC_LAST);
    assign w_count_ticked   = w_tick ? (mode_down ? bcd_dec(r_count) : bcd_inc(r_count))
                                     : r_count;
    assign w_reach_zero     = w_tick && mode_down && (w_count_ticked == '0);
    assign w_run_after_tick = r_running && !w_reach_zero;
    assign w_preset_clamped = bcd_clamp(preset);
    assign w_push           = w_lap_edge & r_running & ~clear;
    assign w_pop            = lap_pop & ~clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_presc    <= '0;
            r_ss_prev  <= 1'b0;
            r_lap_prev <= 1'b0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_ss_prev  <= start_stop;
            r_lap_prev <= lap;
            if (clear) begin
                r_count   <= '0;
                r_presc   <= '0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
                r_ovf     <= 1'b0;
            end else begin
                if (r_running) r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
                r_count <= w_count_ticked;
                if (w_reach_zero) r_done <= 1'b1;
                if (w_push && w_fifo_full && !w_pop) r_ovf <= 1'b1;
                // Tick is applied first; a start edge then toggles the post-tick state
                if (load && !r_running) begin
                    r_count <= w_preset_clamped;
                    r_presc <= '0;
                    r_done  <= 1'b0;
                end else if (w_ss_edge) begin
                    r_running <= w_run_after_tick ? 1'b0
                                                  : !(mode_down && (w_count_ticked == '0));
                end else begin
                    r_running <= w_run_after_tick;
                end
            end
        end
    end

    lap_fifo #(
        .LAP_DEPTH (LAP_DEPTH),
        .WIDTH     (24)
    ) u_lap_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_count),
        .dout  (lap_out),
        .empty (lap_empty),
        .full  (w_fifo_full)
    );

    assign data_out = r_count;
    assign lap_full = w_fifo_full;
    assign lap_ovf  = r_ovf;
    assign running  = r_running;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lap_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lap_timer
// Brief   : Scenario and randomized checks of lap_timer against a time model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lap_timer;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int MAX_MIN = 59;
    localparam int DEPTH   = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MOD     = (MAX_MIN + 1) * 6000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_stop, lap, lap_pop, clear, load, mode_down;
    logic [23:0] preset;
    logic [23:0] data_out, lap_out;
    logic        lap_empty, lap_full, lap_ovf, running, done;

    int checks = 0;
    int errors = 0;

    // Reference model: time kept as total hundredths of a second
    int m_total, m_presc;
    bit m_run, m_done, m_ovf, m_ssp, m_lapp;
    int m_q[$];

    lap_timer #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .MAX_MIN   (MAX_MIN),
        .LAP_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .lap        (lap),
        .lap_pop    (lap_pop),
        .clear      (clear),
        .load       (load),
        .mode_down  (mode_down),
        .preset     (preset),
        .data_out   (data_out),
        .lap_out    (lap_out),
        .lap_empty  (lap_empty),
        .lap_full   (lap_full),
        .lap_ovf    (lap_ovf),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] bcd(input int m, input int s, input int h);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    function automatic logic [23:0] to_bcd(input int total);
        return bcd(total / 6000, (total / 100) % 60, total % 100);
    endfunction

    function automatic int clamp_total(input logic [23:0] p);
        int d5, d4, d3, d2, d1, d0;
        d5 = int'(p[23:20]); d4 = int'(p[19:16]); d3 = int'(p[15:12]);
        d2 = int'(p[11:8]);  d1 = int'(p[7:4]);   d0 = int'(p[3:0]);
        if (d5 > MAX_MIN / 10) d5 = MAX_MIN / 10;
        if (d4 > 9) d4 = 9;
        if (d5 * 10 + d4 > MAX_MIN) d4 = MAX_MIN % 10;
        if (d3 > 5) d3 = 5;
        if (d2 > 9) d2 = 9;
        if (d1 > 9) d1 = 9;
        if (d0 > 9) d0 = 9;
        return (d5 * 10 + d4) * 6000 + (d3 * 10 + d2) * 100 + d1 * 10 + d0;
    endfunction

    task automatic model_reset();
        m_total = 0; m_presc = 0; m_run = 0; m_done = 0; m_ovf = 0;
        m_ssp = 0; m_lapp = 0; m_q.delete();
    endtask

    task automatic model_update();
        bit ss_e, lap_e, tick, run_after;
        int pre;
        ss_e  = start_stop && !m_ssp;
        lap_e = lap && !m_lapp;
        m_ssp  = start_stop;
        m_lapp = lap;
        if (clear) begin
            m_total = 0; m_presc = 0; m_run = 0; m_done = 0; m_ovf = 0;
            m_q.delete();
            return;
        end
        tick = m_run && (m_presc == DIV - 1);
        pre  = m_total;
        if (lap_pop && m_q.size() > 0) void'(m_q.pop_front());
        if (lap_e && m_run) begin
            if (m_q.size() < DEPTH) m_q.push_back(pre);
            else m_ovf = 1;
        end
        if (m_run) m_presc = tick ? 0 : m_presc + 1;
        run_after = m_run;
        if (tick) begin
            if (mode_down) begin
                if (m_total > 0) m_total--;
                if (m_total == 0) begin m_done = 1; run_after = 0; end
            end else begin
                m_total = (m_total + 1) % MOD;
            end
        end
        if (load && !m_run) begin
            m_total = clamp_total(preset); m_presc = 0; m_done = 0;
        end else if (ss_e) begin
            m_run = run_after ? 0 : !(mode_down && m_total == 0);
        end else begin
            m_run = run_after;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_update();
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1; step(1); clear = 0;
    endtask

    task automatic pulse_ss();
        start_stop = 1; step(1); start_stop = 0;
    endtask

    task automatic do_load(input logic [23:0] v);
        preset = v; load = 1; step(1); load = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++; if (data_out !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 000000", data_out); end
        checks++; if (lap_out !== 24'h0) begin errors++; $display("FAIL reset_lap_out: got %h want 000000", lap_out); end
        checks++; if ({lap_empty, lap_full, lap_ovf, running, done} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags: got %b want 10000", {lap_empty, lap_full, lap_ovf, running, done}); end
        reset = 0;
    endtask

    task automatic test_count_up();
        do_clear();
        mode_down = 0;
        pulse_ss();
        step(1000 * DIV);
        checks++; if (data_out !== bcd(0, 10, 0) || running !== 1'b1) begin
            errors++; $display("FAIL up_1000_ticks: got %h run %b want 001000 run 1", data_out, running); end
        pulse_ss();
        step(50);
        checks++; if (data_out !== bcd(0, 10, 0) || running !== 1'b0) begin
            errors++; $display("FAIL up_frozen: got %h run %b want 001000 run 0", data_out, running); end
    endtask

    task automatic test_wrap();
        do_clear();
        mode_down = 0;
        do_load(bcd(59, 59, 99));
        pulse_ss();
        step(DIV - 1);
        checks++; if (data_out !== bcd(59, 59, 99)) begin
            errors++; $display("FAIL wrap_pre: got %h want 595999", data_out); end
        step(1);
        checks++; if (data_out !== 24'h0 || running !== 1'b1) begin
            errors++; $display("FAIL wrap_post: got %h run %b want 000000 run 1", data_out, running); end
        pulse_ss();
    endtask

    task automatic test_countdown();
        do_clear();
        mode_down = 1;
        do_load(bcd(0, 0, 3));
        pulse_ss();
        step(2 * DIV);
        checks++; if (data_out !== bcd(0, 0, 1) || done !== 1'b0) begin
            errors++; $display("FAIL down_mid: got %h done %b want 000001 done 0", data_out, done); end
        step(DIV);
        checks++; if (data_out !== 24'h0 || done !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL down_zero: got %h done %b run %b want 000000 1 0", data_out, done, running); end
        pulse_ss();
        step(2);
        checks++; if (running !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL down_restart_ignored: run %b done %b want 0 1", running, done); end
        mode_down = 0;
    endtask

    task automatic test_lap_fifo();
        do_clear();
        mode_down = 0;
        pulse_ss();
        step(25);
        for (int i = 0; i < 5; i++) begin
            lap = 1; step(1); lap = 0; step(12);
        end
        checks++; if (lap_full !== 1'b1 || lap_ovf !== 1'b1) begin
            errors++; $display("FAIL lap_overflow: full %b ovf %b want 1 1", lap_full, lap_ovf); end
        checks++; if (lap_out !== bcd(0, 0, 2)) begin
            errors++; $display("FAIL lap_head_first: got %h want 000002", lap_out); end
        pulse_ss();
        lap_pop = 1; step(1);
        checks++; if (lap_out !== bcd(0, 0, 3)) begin
            errors++; $display("FAIL lap_head_second: got %h want 000003", lap_out); end
        step(3); lap_pop = 0;
        checks++; if (lap_empty !== 1'b1 || lap_out !== 24'h0 || lap_ovf !== 1'b1) begin
            errors++; $display("FAIL lap_drained: empty %b out %h ovf %b want 1 000000 1", lap_empty, lap_out, lap_ovf); end
    endtask

    task automatic test_lap_on_tick();
        do_clear();
        mode_down = 0;
        do_load(bcd(0, 1, 9));
        pulse_ss();
        step(DIV - 1);
        lap = 1; step(1); lap = 0;
        checks++; if (lap_out !== bcd(0, 1, 9) || data_out !== bcd(0, 1, 10)) begin
            errors++; $display("FAIL lap_on_tick: lap %h data %h want 000109 000110", lap_out, data_out); end
        pulse_ss();
    endtask

    task automatic test_reset_mid();
        do_clear();
        pulse_ss();
        step(37);
        lap = 1; step(1); lap = 0;
        step(5);
        #2 reset = 1;
        #1;
        checks++; if (data_out !== 24'h0 || lap_out !== 24'h0) begin
            errors++; $display("FAIL reset_mid_data: data %h lap %h want 000000 000000", data_out, lap_out); end
        checks++; if ({lap_empty, lap_full, lap_ovf, running, done} !== 5'b10000) begin
            errors++; $display("FAIL reset_mid_flags: got %b want 10000", {lap_empty, lap_full, lap_ovf, running, done}); end
        model_reset();
        reset = 0;
        step(3);
        preset = bcd(12, 34, 56); load = 1; clear = 1; step(1); clear = 0; load = 0;
        checks++; if (data_out !== 24'h0) begin
            errors++; $display("FAIL clear_over_load: got %h want 000000", data_out); end
        do_load(bcd(12, 34, 56));
        checks++; if (data_out !== bcd(12, 34, 56)) begin
            errors++; $display("FAIL load_alone: got %h want 123456", data_out); end
    endtask

    task automatic test_random();
        logic [53:0] exp_v, got_v;
        for (int i = 0; i < 4000; i++) begin
            start_stop = ($urandom_range(0, 19) == 0);
            lap        = ($urandom_range(0, 3) == 0);
            lap_pop    = ($urandom_range(0, 7) == 0);
            clear      = ($urandom_range(0, 499) == 0);
            load       = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 199) == 0) mode_down = ~mode_down;
            preset = ($urandom_range(0, 1) == 1) ? 24'($urandom)
                                                 : bcd(0, 0, $urandom_range(0, 30));
            step(1);
            exp_v = {to_bcd(m_total), (m_q.size() > 0) ? to_bcd(m_q[0]) : 24'h0,
                     m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_run, m_done};
            got_v = {data_out, lap_out, lap_empty, lap_full, lap_ovf, running, done};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h want %h", i, got_v, exp_v);
            end
        end
        {start_stop, lap, lap_pop, clear, load} = '0;
    endtask

    initial begin
        reset = 1;
        {start_stop, lap, lap_pop, clear, load, mode_down} = '0;
        preset = '0;
        model_reset();
        test_reset();
        test_count_up();
        test_wrap();
        test_countdown();
        test_lap_fifo();
        test_lap_on_tick();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, 50_000_000, input clock frequency.
REQ-002 SHALL have parameter TICK_HZ, 100, count resolution (hundredths of a second); CLK_HZ/TICK_HZ integer and >=2.
REQ-003 SHALL have parameter MAX_MIN, 59, highest minutes value (1..99).
REQ-004 SHALL have parameter LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2).
REQ-005 SHALL have port clk input 1, clock.
REQ-006 SHALL have port reset input 1, asynchronous active-high reset.
REQ-007 SHALL have ports start_stop, lap, lap_pop, clear and load, each input 1; start_stop and lap are level inputs acted on at their rising edge, the rest act while high.
REQ-008 SHALL have port mode_down input 1, 1=count down, 0=count up.
REQ-009 SHALL have port preset input 24, BCD mm:ss.hh loaded by load.
REQ-010 SHALL have port data_out output 24, live count as BCD {m_s,m_g,s_s,s_g,hs_s,hs_g}.
REQ-011 SHALL have port lap_out output 24, FIFO head value, same BCD format.
REQ-012 SHALL have ports lap_empty, lap_full, lap_ovf, running and done, each output 1: FIFO status, sticky lap overflow, counting, and countdown expired.

Function
REQ-013 SHALL be one clock domain; the tick is a single-cycle enable and SHALL NOT be used as a clock.
REQ-014 SHALL detect rising edges of start_stop and lap with a registered previous value; the action occurs in the cycle the edge is seen.
REQ-015 SHALL run the prescaler 0..CLK_HZ/TICK_HZ-1 only while running, pulsing tick at the terminal count; the prescaler holds its value while stopped.
REQ-016 SHALL, on tick in up mode, increment a BCD cascade: hs 00-99, s 00-59, m 00-MAX_MIN; MAX_MIN:59.99 wraps to 00:00.00 and keeps running.
REQ-017 SHALL, on tick in down mode, decrement the cascade (borrow 00 hs -> 99, 00 s -> 59); on reaching 00:00.00 it sets done=1 and running=0 in the same cycle.
REQ-018 SHALL toggle running on a start_stop edge, except that a start in down mode with count 00:00.00 is ignored and leaves running=0.
REQ-019 SHALL, when tick and a start_stop edge coincide, apply the tick, then toggle running.
REQ-020 SHALL sample mode_down at every tick; changing it has no other effect.
REQ-021 SHALL apply load only while running=0: count <= preset, with each digit clamped to its maximum (9, 5, or the MAX_MIN digits); prescaler <= 0; done <= 0.
REQ-022 SHALL make clear zero the count, prescaler, running, done, lap FIFO and lap_ovf; priority is clear > load > start_stop edge.
REQ-023 SHALL, on a lap edge while running, push the pre-tick count into the FIFO.
REQ-024 SHALL, on a lap edge while stopped, push nothing.
REQ-025 SHALL, when the FIFO is full, drop the push and set lap_ovf; lap_ovf is cleared only by clear or reset.
REQ-026 SHALL make lap_pop remove the head when not empty, and ignore it when empty.
REQ-027 SHALL, on a simultaneous push and pop, perform both, with occupancy unchanged even when full.
REQ-028 SHALL make lap_out equal 0 when lap_empty=1.

Reset
REQ-029 SHALL, on asynchronous reset, clear count, prescaler, edge registers, FIFO pointers, running, done and lap_ovf, with data_out=0, lap_out=0, lap_empty=1 and lap_full=0.
REQ-030 SHALL synchronise reset deassertion outside the block; reset mid-count discards all state with no partial update.

Structure
REQ-031 SHALL place the BCD digit width, digit maxima, a 24-bit time type and the prescaler-width function in package lap_timer_pkg.
REQ-032 SHALL implement the FIFO as sub-module lap_fifo (parameter LAP_DEPTH, width 24), sized with $clog2.

Verification (CLK_HZ=1000, TICK_HZ=100: tick every 10 clk)
REQ-033 SHALL test: start edge, 1000 ticks -> data_out=00:10.00; a second edge freezes it; 50 further clocks give no change.
REQ-034 SHALL test: load 59:59.99 in up mode (MAX_MIN=59), start, 1 tick -> 00:00.00 with running=1.
REQ-035 SHALL test: load 00:00.03 in down mode, start, 3 ticks -> 00:00.00, done=1, running=0; another start edge is ignored.
REQ-036 SHALL test: 5 lap edges while running with LAP_DEPTH=4 -> lap_full=1, lap_ovf=1, head equals the first lap; 4 pops -> lap_empty=1, lap_out=0.
REQ-037 SHALL test: a lap edge on the tick cycle at 00:01.09 -> the captured value is 00:01.09 and data_out=00:01.10.
REQ-038 SHALL test: reset asserted mid-count and clear with load both high -> all outputs at reset values; clear wins over load.
